// File: rtl/display_capture_pkg.sv
// Shared widths, scaling constants and capture-FSM encoding for the display feeder.
package display_capture_pkg;

    localparam int cstTimeW       = 8;
    localparam int cstAddrW       = 10;
    localparam int cstSampleW     = 12;
    localparam int cstMagW        = 16;
    localparam int cstScaleOffset = 2048;
    localparam int cstScaleShift  = 5;

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        HOLDOFF   = 2'd3
    } capState_t;

endpackage

// File: rtl/display_capture_freq.sv
// Frequency path: tracks the FFT bin index and writes scaled, saturated magnitudes.
module freq_bin_writer
    import display_capture_pkg::*;
#(
    parameter int cstFreqBins  = 100,
    parameter int cstFreqShift = 6
) (
    input  logic                ck100MHz,
    input  logic                rstLow,
    input  logic                flgFreqValid,
    input  logic                flgFreqFirst,
    input  logic [cstMagW-1:0]  freqMag,
    input  logic                flgFreeze,
    output logic                weaFreq,
    output logic [cstAddrW-1:0] addraFreq,
    output logic [cstTimeW-1:0] dinaFreq
);

    localparam logic [cstAddrW-1:0] cstBinLimit = cstAddrW'(cstFreqBins);

    logic                freqSeen;
    logic                seenNext;
    logic                wrFreq;
    logic [cstAddrW-1:0] binIdx;
    logic [cstAddrW-1:0] binIdxNext;

    function automatic logic [cstTimeW-1:0] satMag(input logic [cstMagW-1:0] mag);
        logic [cstMagW-1:0] shifted;
        shifted = mag >> cstFreqShift;
        return (|shifted[cstMagW-1:cstTimeW]) ? '1 : shifted[cstTimeW-1:0];
    endfunction

    // Index saturates at the bin limit so trailing bins of a long frame never wrap onto address 0.
    always_comb begin
        seenNext   = freqSeen;
        binIdxNext = binIdx;
        wrFreq     = 1'b0;
        if (flgFreqValid) begin
            if (flgFreqFirst) begin
                seenNext   = 1'b1;
                binIdxNext = '0;
                wrFreq     = !flgFreeze;
            end else if (freqSeen) begin
                if (binIdx < cstBinLimit) begin
                    binIdxNext = binIdx + cstAddrW'(1);
                end
                wrFreq = !flgFreeze && (binIdxNext < cstBinLimit);
            end
        end
    end

    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            freqSeen  <= 1'b0;
            binIdx    <= '0;
            weaFreq   <= 1'b0;
            addraFreq <= '0;
            dinaFreq  <= '0;
        end else begin
            freqSeen <= seenNext;
            binIdx   <= binIdxNext;
            weaFreq  <= wrFreq;
            if (wrFreq) begin
                addraFreq <= binIdxNext;
                dinaFreq  <= satMag(freqMag);
            end
        end
    end

endmodule

// File: rtl/display_capture.sv
// Triggered oscilloscope capture of the audio stream plus FFT bin feeder for the display memories.
module display_capture
    import display_capture_pkg::*;
#(
    parameter int                           cstHorSize     = 800,
    parameter int                           cstFreqBins    = 100,
    parameter logic signed [cstSampleW-1:0] cstTrigLevel   = '0,
    parameter int                           cstTrigTimeout = 4096,
    parameter int                           cstHoldoff     = 256,
    parameter int                           cstFreqShift   = 6
) (
    input  logic                         ck100MHz,
    input  logic                         rstLow,
    input  logic                         flgSampleValid,
    input  logic signed [cstSampleW-1:0] sample,
    input  logic                         flgFreqValid,
    input  logic                         flgFreqFirst,
    input  logic [cstMagW-1:0]           freqMag,
    input  logic                         flgFreeze,
    output logic                         enaTime,
    output logic                         weaTime,
    output logic [cstAddrW-1:0]          addraTime,
    output logic [cstTimeW-1:0]          dinaTime,
    output logic                         weaFreq,
    output logic [cstAddrW-1:0]          addraFreq,
    output logic [cstTimeW-1:0]          dinaFreq,
    output logic                         flgFrameDone,
    output logic                         flgTrigd
);

    localparam int cstCntW = 16;

    capState_t                    state;
    capState_t                    stateNext;
    logic [cstCntW-1:0]           cnt;
    logic [cstCntW-1:0]           cntNext;
    logic signed [cstSampleW-1:0] prev;
    logic                         trigHit;
    logic                         wrTime;
    logic                         doneNext;
    logic                         trigdNext;
    logic [cstAddrW-1:0]          addrNext;

    // Offset-binary conversion: adding the half-scale offset modulo 2^12 maps -2048..2047 to 0..4095.
    function automatic logic [cstTimeW-1:0] scaleTime(input logic signed [cstSampleW-1:0] s);
        logic [cstSampleW-1:0] biased;
        biased = s + cstSampleW'(cstScaleOffset);
        return cstTimeW'(biased >> cstScaleShift);
    endfunction

    assign trigHit = (prev < cstTrigLevel) && (sample >= cstTrigLevel);

    // One counter serves as trigger timeout, capture address and holdoff count.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        wrTime    = 1'b0;
        doneNext  = 1'b0;
        trigdNext = flgTrigd;
        addrNext  = cnt[cstAddrW-1:0];
        if (flgSampleValid) begin
            unique case (state)
                ARM: begin
                    if (!flgFreeze) begin
                        cntNext   = '0;
                        stateNext = WAIT_TRIG;
                    end
                end
                WAIT_TRIG: begin
                    if (trigHit || (cnt == cstCntW'(cstTrigTimeout - 1))) begin
                        wrTime    = 1'b1;
                        addrNext  = '0;
                        trigdNext = trigHit;
                        cntNext   = cstCntW'(1);
                        stateNext = CAPTURE;
                    end else begin
                        cntNext = cnt + cstCntW'(1);
                    end
                end
                CAPTURE: begin
                    wrTime = 1'b1;
                    if (cnt == cstCntW'(cstHorSize - 1)) begin
                        doneNext  = 1'b1;
                        cntNext   = '0;
                        stateNext = HOLDOFF;
                    end else begin
                        cntNext = cnt + cstCntW'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == cstCntW'(cstHoldoff - 1)) begin
                        cntNext   = '0;
                        stateNext = ARM;
                    end else begin
                        cntNext = cnt + cstCntW'(1);
                    end
                end
                default: stateNext = ARM;
            endcase
        end
    end

    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            state <= ARM;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge ck100MHz) begin
        if (!rstLow) begin
            cnt          <= '0;
            prev         <= '0;
            enaTime      <= 1'b0;
            weaTime      <= 1'b0;
            addraTime    <= '0;
            dinaTime     <= '0;
            flgFrameDone <= 1'b0;
            flgTrigd     <= 1'b0;
        end else begin
            cnt          <= cntNext;
            enaTime      <= wrTime;
            weaTime      <= wrTime;
            flgFrameDone <= doneNext;
            flgTrigd     <= trigdNext;
            if (flgSampleValid) begin
                prev <= sample;
            end
            if (wrTime) begin
                addraTime <= addrNext;
                dinaTime  <= scaleTime(sample);
            end
        end
    end

    freq_bin_writer #(
        .cstFreqBins (cstFreqBins),
        .cstFreqShift(cstFreqShift)
    ) freqWriter (
        .ck100MHz    (ck100MHz),
        .rstLow      (rstLow),
        .flgFreqValid(flgFreqValid),
        .flgFreqFirst(flgFreqFirst),
        .freqMag     (freqMag),
        .flgFreeze   (flgFreeze),
        .weaFreq     (weaFreq),
        .addraFreq   (addraFreq),
        .dinaFreq    (dinaFreq)
    );

endmodule

// File: doc/display_capture.md
Name: display_capture

Overview:
- Upstream feeder for the image controller's two display block memories.
- Time path: a triggered oscilloscope capture. It turns the audio sample stream into one screen-width frame of 8-bit display samples and writes them through the time-domain memory write port.
- Frequency path: it scales and saturates FFT magnitude bins and writes them through the frequency-domain memory write port.
- Runs entirely in the ck100MHz domain.

Parameters:
- cstHorSize, 800, number of time samples per captured frame (addresses 0..cstHorSize-1).
- cstFreqBins, 100, number of FFT bins written (bins >= cstFreqBins are dropped).
- cstTrigLevel, 0, signed 12-bit rising-edge trigger level.
- cstTrigTimeout, 4096, samples waited for a trigger before forced (auto) capture.
- cstHoldoff, 256, samples ignored after a frame before re-arming.
- cstFreqShift, 6, right shift applied to magnitude before saturation to 8 bits.

Ports:
- ck100MHz  in  1  system clock
- rstLow  in  1  reset
- flgSampleValid  in  1  one-cycle strobe, sample is valid
- sample  in  12  signed two's-complement audio sample
- flgFreqValid  in  1  one-cycle strobe, freqMag is valid
- flgFreqFirst  in  1  qualifies flgFreqValid; marks bin 0
- freqMag  in  16  unsigned FFT magnitude
- flgFreeze  in  1  high = hold current display, no new frames
- enaTime  out  1  time memory port enable
- weaTime  out  1  time memory write enable
- addraTime  out  10  time memory write address
- dinaTime  out  8  time memory write data
- weaFreq  out  1  freq memory write enable
- addraFreq  out  10  freq memory write address
- dinaFreq  out  8  freq memory write data
- flgFrameDone  out  1  one-cycle pulse, last time sample written
- flgTrigd  out  1  level: last frame began on a real trigger (0 = auto)

Behaviour:
- Clock and reset:
  - Single clock ck100MHz.
  - Reset is synchronous, active-low, on rstLow.
  - While rstLow=0 all outputs are 0, the FSM is in ARM, all counters are 0, the previous-sample register is 0, and freqSeen is 0.
  - Reset asserted mid-frame aborts the frame; no further writes occur.
- Outputs: all registered. A write appears exactly 1 cycle after the qualifying input strobe. enaTime equals weaTime.
- Time scaling: dinaTime = {1'b0, (sample + 2048) >> 5}, giving range 0..127 (−2048→0, 0→64, 2047→127).
- Time FSM, advanced only on flgSampleValid (samples are the unit for all counts):
  - ARM:
    - If flgFreeze=1, stay in ARM.
    - Otherwise clear the timeout counter and go to WAIT_TRIG. The current sample is not written.
  - WAIT_TRIG:
    - Trigger when prev < cstTrigLevel and sample >= cstTrigLevel (signed compare). The triggering sample goes to address 0, flgTrigd<=1, next state CAPTURE.
    - Otherwise the timeout counter increments. On the cstTrigTimeout-th non-triggering sample, that sample goes to address 0, flgTrigd<=0, next state CAPTURE.
  - CAPTURE:
    - Each sample is written to address n = 1..cstHorSize-1.
    - The write to address cstHorSize-1 pulses flgFrameDone in the same cycle as that weaTime.
    - Next state HOLDOFF.
  - HOLDOFF: count cstHoldoff samples, then go to ARM.
  - flgFreeze is sampled only in ARM. A frame in progress always completes.
- prev register: updates on every flgSampleValid, in every state.
- Frequency path:
  - freqSeen is set by the first flgFreqValid && flgFreqFirst after reset. Valid strobes before that are ignored.
  - On flgFreqValid && flgFreqFirst, the bin index becomes 0 and that magnitude is written to address 0.
  - On flgFreqValid without flgFreqFirst, the index increments by 1 and the bin is written.
  - A bin is written only when index < cstFreqBins and flgFreeze=0. The index saturates at cstFreqBins and does not wrap.
  - dinaFreq = ((freqMag >> cstFreqShift) > 255) ? 255 : (freqMag >> cstFreqShift).
- Simultaneous time and frequency strobes: independent ports, both written in the same cycle.

Decomposition:
- Shared package holds:
  - the FSM state encoding (ARM, WAIT_TRIG, CAPTURE, HOLDOFF; 2 bits);
  - widths: time data 8, address 10, sample 12, magnitude 16;
  - the scale offset 2048 and shift 5.
- One natural sub-module: freq_bin_writer, the frequency path (freqSeen flag, bin index, saturating scale, write strobe). The time FSM stays in the top module.

Test Plan:
- Reset behaviour: pulse rstLow=0 for 3 cycles with strobes active -> all outputs 0. First write occurs only after ARM→WAIT_TRIG and a crossing.
- Triggered ramp:
  - Stimulus: sine, amplitude 1000, 1 sample per 10 cycles, cstTrigLevel=0.
  - Address 0 holds the first sample >= 0 following a negative sample.
  - Addresses run 0..799 contiguously, each write 1 cycle after its strobe.
  - flgFrameDone pulses once with addraTime=799. flgTrigd=1.
- Auto trigger: constant sample=500, cstTrigTimeout=16 -> capture starts on the 16th WAIT_TRIG sample, dinaTime=79 everywhere, flgTrigd=0.
- Holdoff and freeze:
  - After a frame, zero writes occur for 256 samples.
  - With flgFreeze=1 raised mid-CAPTURE, the frame completes to 799 and no further time writes occur until flgFreeze=0.
- Frequency scaling:
  - Before the first flgFreqFirst, 5 strobes -> no writes.
  - Then a frame of 120 bins with freqMag=bin*1000:
    - bin 0 → 0;
    - bin 10 → 156;
    - bin 17 → 255 (saturated);
    - bins 100..119 not written.
- Reset mid-frame: rstLow=0 during CAPTURE at address 400 -> weaTime 0 next cycle, no flgFrameDone. The next frame restarts at address 0.
